wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus integer register file of the RISC-V pipeline.
- Consumes the MEM/WB pipeline register outputs: the control bits W, memory data, ALU result and destination register number.
- Selects the write-back value and commits it to a 32-entry register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- After reset, runs a scrub state machine that zeroes the array one entry per cycle and asserts busy while doing so.

Parameters:
- XLEN, 64, data width.
- NREG, 32, register count; index width is log2(NREG).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clk edge).
- W  in  3  write-back control: W[0]=RegWrite, W[1]=MemToReg, W[2] reserved and ignored.
- mem_d_out  in  XLEN  load data from MEM/WB.
- ALU_out  in  XLEN  ALU result from MEM/WB.
- RD_n  in  5  destination register number.
- funct3  in  3  load size/sign; used only with WB_LOAD_EXT_EN, ignored otherwise.
- rs1_n, rs2_n  in  5  ID-stage source register numbers.
- rs1_data, rs2_data  out  XLEN  read data (combinational).
- wb_data  out  XLEN  selected write-back value (combinational), for EX forwarding.
- wb_we  out  1  effective write enable (combinational).
- busy  out  1  scrub in progress; hazard unit stalls the pipeline while high.

Behaviour:
- Write-back select: wb_data = W[1] ? mem_d_out (after extension, if enabled) : ALU_out.
- Write enable: wb_we = W[0] & (RD_n != 0) & ~busy.
- Commit: on a clk edge with wb_we==1, reg[RD_n] <= wb_data.
- x0: never written; always reads 0.
- Read port, per port p:
  - busy==1 -> 0.
  - rsp_n==0 -> 0.
  - wb_we & (rsp_n==RD_n) -> wb_data (write-through bypass).
  - otherwise reg[rsp_n].
- Simultaneous rs1_n==rs2_n==RD_n: both ports get the bypassed wb_data.
- FSM states: SCRUB, RUN. Registered state, scrub index idx (5 bits) and busy.
- Reset (rst==0 at an edge): state<=SCRUB, idx<=1, busy<=1. Array contents are not cleared by reset itself.
- SCRUB: each edge writes reg[idx]<=0 and increments idx. On the edge that writes idx==NREG-1: state<=RUN, busy<=0.
  - busy is high for exactly NREG-1 = 31 cycles after rst returns to 1.
  - Write-back requests during SCRUB are dropped; upstream must hold them via the stall.
- RUN: normal operation; stays in RUN until the next reset.
- Reset mid-scrub: restarts at idx=1; busy stays high.
- Reset values:
  - busy=1 (registered).
  - rs1_data, rs2_data = 0 (forced by busy).
  - wb_data and wb_we are combinational from inputs; wb_we=0 while busy.
- Latency: write-back is visible at read ports in the same cycle (bypass) and in the array from the next cycle.

Optional Feature:
- Macro WB_LOAD_EXT_EN.
- Defined: when W[1]==1, mem_d_out is extended per funct3 before selection:
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: sign-extend [31:0].
  - 011 LD: pass through.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend the same fields.
  - 111: pass through.
- Not defined: mem_d_out passes through unchanged (MEM stage already extends); funct3 is unused.

Decomposition:
- Shared package:
  - XLEN, NREG.
  - W bit indices WB_REGWRITE=0, WB_MEMTOREG=1.
  - funct3 load codes.
  - FSM state encoding (SCRUB=1'b0, RUN=1'b1).
- Sub-module load_ext: combinational extender, instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- Reset scrub: hold rst=0 for 2 cycles, release -> busy=1 for exactly 31 cycles, then 0; a prior value in x5 reads 0 afterwards; a write to x3 during busy is dropped.
- Basic ALU write-back: W=3'b001, ALU_out=64'h1234, RD_n=7 -> wb_we=1; next cycle rs1_n=7 reads 64'h1234.
- Bypass and x0: W=3'b011, mem_d_out=64'hDEAD, RD_n=9, rs1_n=rs2_n=9 in the same cycle -> both ports read 64'hDEAD. Then RD_n=0, W=3'b001 -> wb_we=0 and x0 still reads 0.
- Reset mid-scrub: drop rst at scrub cycle 10 -> busy stays 1 and deasserts 31 cycles after rst releases.
- WB_LOAD_EXT_EN defined, W=3'b011, mem_d_out=64'h0000_0000_0000_0080:
  - funct3=000 -> x4 = 64'hFFFF_FFFF_FFFF_FF80.
  - funct3=100 -> x4 = 64'h80.
  - Macro undefined -> x4 = 64'h80 for both funct3 values.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and integer register file.
package wb_regfile_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned IDXW = $clog2(NREG);

    // Bit positions inside the W control bundle; bit 2 is reserved
    localparam int unsigned WB_REGWRITE = 0;
    localparam int unsigned WB_MEMTOREG = 1;
    localparam int unsigned WB_RESERVED = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        StScrub = 1'b0,
        StRun   = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load-data sign/zero extender selected by funct3.
// Only built when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module wb_regfile_load_ext import wb_regfile_pkg::*; (
    input  logic [XLEN-1:0] din,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] dout
);

    always_comb begin
        dout = din;
        case (funct3)
            F3_LB:   dout = {{(XLEN-8){din[7]}}, din[7:0]};
            F3_LH:   dout = {{(XLEN-16){din[15]}}, din[15:0]};
            F3_LW:   dout = {{(XLEN-32){din[31]}}, din[31:0]};
            F3_LBU:  dout = {{(XLEN-8){1'b0}}, din[7:0]};
            F3_LHU:  dout = {{(XLEN-16){1'b0}}, din[15:0]};
            F3_LWU:  dout = {{(XLEN-32){1'b0}}, din[31:0]};
            default: dout = din;
        endcase
    end

endmodule
`endif

// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry integer register file with write-through read bypass
// and a post-reset scrub. Define WB_LOAD_EXT_EN to extend load data here by funct3.
module wb_regfile import wb_regfile_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      W,
    input  logic [XLEN-1:0] mem_d_out,
    input  logic [XLEN-1:0] ALU_out,
    input  logic [IDXW-1:0] RD_n,
    input  logic [2:0]      funct3,
    input  logic [IDXW-1:0] rs1_n,
    input  logic [IDXW-1:0] rs2_n,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic            busy
);

    logic [XLEN-1:0] regs_q [NREG];
    wb_state_e       state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] mem_data;
    logic            arr_we;
    logic [IDXW-1:0] arr_idx;
    logic [XLEN-1:0] arr_wdata;

`ifdef WB_LOAD_EXT_EN
    wb_regfile_load_ext u_load_ext (
        .din    (mem_d_out),
        .funct3 (funct3),
        .dout   (mem_data)
    );
    logic unused_w;
    assign unused_w = W[WB_RESERVED];
`else
    // MEM stage has already extended the load data
    assign mem_data = mem_d_out;
    logic unused_bits;
    assign unused_bits = ^{W[WB_RESERVED], funct3};
`endif

    assign wb_data = W[WB_MEMTOREG] ? mem_data : ALU_out;
    assign wb_we   = W[WB_REGWRITE] & (RD_n != '0) & ~busy_q;
    assign busy    = busy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            StScrub: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NREG - 1)) begin
                    state_d = StRun;
                    busy_d  = 1'b0;
                end
            end
            StRun: begin
            end
            default: state_d = StScrub;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StScrub;
            idx_q   <= IDXW'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Scrub and write-back never overlap: wb_we is gated by busy
    always_comb begin
        arr_we    = 1'b0;
        arr_idx   = RD_n;
        arr_wdata = wb_data;
        if (state_q == StScrub) begin
            arr_we    = 1'b1;
            arr_idx   = idx_q;
            arr_wdata = '0;
        end else if (wb_we) begin
            arr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && arr_we) begin
            regs_q[arr_idx] <= arr_wdata;
        end
    end

    assign rs1_data = (busy_q || rs1_n == '0) ? '0 :
                      (wb_we && rs1_n == RD_n) ? wb_data : regs_q[rs1_n];
    assign rs2_data = (busy_q || rs2_n == '0) ? '0 :
                      (wb_we && rs2_n == RD_n) ? wb_data : regs_q[rs2_n];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: scrub timing, write-back, bypass, x0 and load extension.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  W;
    logic [63:0] mem_d_out;
    logic [63:0] ALU_out;
    logic [4:0]  RD_n;
    logic [2:0]  funct3;
    logic [4:0]  rs1_n;
    logic [4:0]  rs2_n;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] wb_data;
    logic        wb_we;
    logic        busy;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .W         (W),
        .mem_d_out (mem_d_out),
        .ALU_out   (ALU_out),
        .RD_n      (RD_n),
        .funct3    (funct3),
        .rs1_n     (rs1_n),
        .rs2_n     (rs2_n),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .busy      (busy)
    );

`ifdef WB_LOAD_EXT_EN
    localparam logic [63:0] EXP_LB = 64'hFFFF_FFFF_FFFF_FF80;
`else
    localparam logic [63:0] EXP_LB = 64'h80;
`endif

    typedef struct {
        logic [2:0]  w;
        logic [63:0] mem;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        we;
        logic [63:0] wb;
        logic [63:0] d1;
        logic [63:0] d2;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] val;
    } sb_t;

    vec_t vecs[9];
    sb_t  sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   nbusy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive on the falling edge, let the combinational outputs settle, return before rising edge
    task automatic apply(input logic [2:0] w, input logic [63:0] mem, input logic [63:0] alu,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2);
        @(negedge clk);
        W = w; mem_d_out = mem; ALU_out = alu; funct3 = f3; RD_n = rd; rs1_n = r1; rs2_n = r2;
        #2;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
    endtask

    task automatic drain_sb();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            apply(3'b000, 64'h0, 64'h0, 3'b011, 5'd0, e.rd, 5'd0);
            check($sformatf("sb_x%0d", e.rd), rs1_data, e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b001, 64'h0,    64'h1234, 5'd7,  5'd7,  5'd0,  1'b1, 64'h1234, 64'h1234, 64'h0};
        vecs[1] = '{3'b000, 64'h0,    64'h5555, 5'd7,  5'd7,  5'd7,  1'b0, 64'h5555, 64'h1234, 64'h1234};
        vecs[2] = '{3'b011, 64'hDEAD, 64'h1111, 5'd9,  5'd9,  5'd9,  1'b1, 64'hDEAD, 64'hDEAD, 64'hDEAD};
        vecs[3] = '{3'b001, 64'h0,    64'hBEEF, 5'd0,  5'd0,  5'd9,  1'b0, 64'hBEEF, 64'h0,    64'hDEAD};
        vecs[4] = '{3'b100, 64'h0,    64'h9999, 5'd7,  5'd7,  5'd9,  1'b0, 64'h9999, 64'h1234, 64'hDEAD};
        vecs[5] = '{3'b101, 64'h0,    64'hAAAA, 5'd10, 5'd10, 5'd0,  1'b1, 64'hAAAA, 64'hAAAA, 64'h0};
        vecs[6] = '{3'b010, 64'h77,   64'h22,   5'd11, 5'd10, 5'd11, 1'b0, 64'h77,   64'hAAAA, 64'h0};
        vecs[7] = '{3'b001, 64'h0,    '1,       5'd31, 5'd31, 5'd7,  1'b1, '1,       '1,       64'h1234};
        vecs[8] = '{3'b000, 64'h0,    64'h0,    5'd0,  5'd31, 5'd0,  1'b0, 64'h0,    '1,       64'h0};

        rst = 1'b0; W = 3'b000; mem_d_out = '0; ALU_out = '0; RD_n = '0;
        funct3 = 3'b011; rs1_n = '0; rs2_n = '0;

        // Power-up reset and scrub
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        count_busy(nbusy);
        check("init_scrub_len", 64'(nbusy), 64'd31);

        // Plant a value in x5 before the second reset
        apply(3'b001, 64'h0, 64'hABCD, 3'b011, 5'd5, 5'd0, 5'd0);
        apply(3'b000, 64'h0, 64'h0, 3'b011, 5'd0, 5'd5, 5'd0);
        check("x5_before_reset", rs1_data, 64'hABCD);

        // Reset with a write to x3 held for the whole scrub
        @(negedge clk);
        rst = 1'b0; W = 3'b001; ALU_out = 64'h333; RD_n = 5'd3; rs1_n = 5'd3; rs2_n = 5'd5;
        @(posedge clk);
        #2;
        check("rst_busy", busy, 1'b1);
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_wb_data", wb_data, 64'h333);
        check("rst_rs1_zero", rs1_data, 64'h0);
        check("rst_rs2_zero", rs2_data, 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy(nbusy);
        W = 3'b000;
        check("scrub_len", 64'(nbusy), 64'd31);
        apply(3'b000, 64'h0, 64'h0, 3'b011, 5'd0, 5'd3, 5'd5);
        check("x3_dropped", rs1_data, 64'h0);
        check("x5_scrubbed", rs2_data, 64'h0);
        check("busy_low", busy, 1'b0);

        // Reset again ten cycles into the scrub
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_scrub_busy", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_busy", busy, 1'b1);
        rst = 1'b1;
        count_busy(nbusy);
        check("mid_scrub_len", 64'(nbusy), 64'd31);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].w, vecs[i].mem, vecs[i].alu, 3'b011, vecs[i].rd, vecs[i].r1, vecs[i].r2);
            check($sformatf("vec%0d_we", i), wb_we, vecs[i].we);
            check($sformatf("vec%0d_wb", i), wb_data, vecs[i].wb);
            check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].d1);
            check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].d2);
            if (vecs[i].we) sbq.push_back('{vecs[i].rd, vecs[i].wb});
        end
        drain_sb();

        // Load extension of a byte with bit 7 set
        apply(3'b011, 64'h80, 64'h0, 3'b000, 5'd4, 5'd4, 5'd0);
        check("lb_wb_data", wb_data, EXP_LB);
        check("lb_bypass", rs1_data, EXP_LB);
        sbq.push_back('{5'd4, EXP_LB});
        drain_sb();
        apply(3'b011, 64'h80, 64'h0, 3'b100, 5'd4, 5'd0, 5'd4);
        check("lbu_wb_data", wb_data, 64'h80);
        check("lbu_bypass", rs2_data, 64'h80);
        sbq.push_back('{5'd4, 64'h80});
        drain_sb();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
